// File: rtl/cam_pkg.sv
// cam_pkg: shared CAM constants and resolver state encoding
package cam_pkg;
  localparam int CAM_WORDS = 100;
  localparam int CAM_BITS = 32;
  localparam int CAM_IDX_W = 7;
  typedef enum logic [2:0] {IDLE, SETTLE_WAIT, PICK, PRESENT, DONE} resolver_state_t;
endpackage

// File: rtl/lowest_set_encoder.sv
// lowest_set_encoder: index of the lowest set bit of a vector plus a found flag
module lowest_set_encoder
  import cam_pkg::*;
#(
  parameter int WORDS = CAM_WORDS,
  parameter int IDX_W = CAM_IDX_W
) (
  input  logic [WORDS-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);
  // scan high to low so the lowest set bit is the last one written
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int i = WORDS - 1; i >= 0; i--)
      if (vec[i]) begin
        idx = IDX_W'(i);
        found = 1'b1;
      end
  end
endmodule

// File: rtl/match_resolver.sv
// match_resolver: tags responding CAM words and presents them lowest-index-first
module match_resolver
  import cam_pkg::*;
#(
  parameter int WORDS = CAM_WORDS,
  parameter int IDX_W = CAM_IDX_W,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WORDS-1:0] mismatch_in,
  input  logic [WORDS-1:0] word_valid,
  input  logic             start,
  input  logic             next,
  output logic             busy,
  output logic             hit_valid,
  output logic [IDX_W-1:0] hit_idx,
  output logic [IDX_W:0]   hit_count,
  output logic             any_hit,
  output logic             done
);
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);
  resolver_state_t state, state_n;
  logic [3:0] cnt;
  logic [WORDS-1:0] tag;
  logic [WORDS-1:0] resp;
  logic [IDX_W-1:0] enc_idx;
  logic enc_found;
  assign resp = word_valid & ~mismatch_in;
  lowest_set_encoder #(.WORDS(WORDS), .IDX_W(IDX_W)) u_enc (
    .vec(tag),
    .idx(enc_idx),
    .found(enc_found)
  );
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // next state; start restarts resolution from any state
  always_comb begin
    state_n = state;
    if (start) state_n = SETTLE_WAIT;
    else
      unique case (state)
        IDLE:        state_n = IDLE;
        SETTLE_WAIT: state_n = cnt == 4'd0 ? PICK : SETTLE_WAIT;
        PICK:        state_n = enc_found ? PRESENT : DONE;
        PRESENT:     state_n = next ? PICK : PRESENT;
        DONE:        state_n = IDLE;
        default:     state_n = IDLE;
      endcase
  end
  // state-decoded outputs
  always_comb begin
    busy = state != IDLE;
    hit_valid = state == PRESENT;
    done = state == DONE;
  end
  // settle counter, tag register and responder bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      tag <= '0;
      hit_idx <= '0;
      hit_count <= '0;
      any_hit <= 1'b0;
    end else if (start) begin
      cnt <= SETTLE_LD;
      tag <= '0;
      any_hit <= 1'b0;
    end else if (state == SETTLE_WAIT) begin
      if (cnt != 4'd0) cnt <= cnt - 4'd1;
      else begin
        tag <= resp;
        hit_count <= (IDX_W+1)'($countones(resp));
        any_hit <= |resp;
      end
    end else if (state == PICK) begin
      if (enc_found) hit_idx <= enc_idx;
      else hit_count <= '0;
    end else if (state == PRESENT && next) begin
      tag[hit_idx] <= 1'b0;
      hit_count <= hit_count - 1'b1;
    end
  end
endmodule
